// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared constants for the memory controller: FSM state
//               encodings, lsb_len request encodings, IO region marker and
//               a helper that turns an lsb_len code into a byte count.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] MC_IDLE = 2'd0;
    localparam logic [1:0] MC_IF   = 2'd1;   // instruction line fill
    localparam logic [1:0] MC_LR   = 2'd2;   // LSB load
    localparam logic [1:0] MC_LW   = 2'd3;   // LSB store

    // lsb_len encodings
    localparam logic [1:0] LSB_LEN_1 = 2'b00;
    localparam logic [1:0] LSB_LEN_2 = 2'b01;
    localparam logic [1:0] LSB_LEN_4 = 2'b10;

    // addr[17:16] value that marks the IO region (0x30000 and above)
    localparam logic [1:0] MC_IO_ADDR_HI = 2'b11;

    // Byte count of an LSB access; the unused code 2'b11 is treated as a word.
    function automatic logic [2:0] lsb_len_bytes(input logic [1:0] len);
        case (len)
            LSB_LEN_1: return 3'd1;
            LSB_LEN_2: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Responder for instruction line fills plus the load/store
//               data port, driving a byte-wide unified RAM/IO bus one byte
//               per cycle. The LSB has priority over instruction fetch.
// Ports       : clk, rst_n (async, active-low), rdy (global enable)
//               mem_din/mem_dout/mem_a/mem_wr - byte-wide RAM/IO bus
//               io_buffer_full                - stalls IO-region writes
//               if_en/if_pc/if_done/if_data   - line fill request/response
//               lsb_en/lsb_wr/lsb_addr/lsb_len/lsb_w_data/lsb_done/
//               lsb_r_data                    - load/store request/response
//               rollback                      - aborts an in-flight load
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         LINE_BYTES = 64,
    parameter logic [1:0] IO_ADDR_HI = MC_IO_ADDR_HI
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    input  logic                      io_buffer_full,
    input  logic                      if_en,
    input  logic [31:0]               if_pc,
    output logic                      if_done,
    output logic [8*LINE_BYTES-1:0]   if_data,
    input  logic                      lsb_en,
    input  logic                      lsb_wr,
    input  logic [31:0]               lsb_addr,
    input  logic [1:0]                lsb_len,
    input  logic [31:0]               lsb_w_data,
    output logic                      lsb_done,
    output logic [31:0]               lsb_r_data,
    input  logic                      rollback
);

    localparam int                 c_IDX_W  = $clog2(LINE_BYTES);
    // Read counter must reach LINE_BYTES+1 (the done edge of a line fill)
    localparam int                 c_CNT_W  = $clog2(LINE_BYTES + 2);
    localparam logic [c_CNT_W-1:0] c_LINE_N = c_CNT_W'(LINE_BYTES);

    logic [1:0]              r_state;
    logic [c_CNT_W-1:0]      r_cnt;      // edges since acceptance minus one (reads) / bytes written (writes)
    logic [c_CNT_W-1:0]      r_len;      // transfer length in bytes
    logic [31:0]             r_mem_a;
    logic [7:0]              r_mem_dout;
    logic                    r_mem_wr;
    logic [31:0]             r_wdata;    // store data, shifted one byte per written byte
    logic [31:0]             r_ld_buf;   // load assembly buffer, copied out on completion
    logic                    r_if_done;
    logic [8*LINE_BYTES-1:0] r_if_data;
    logic                    r_lsb_done;
    logic [31:0]             r_lsb_r_data;

    logic                    w_stall;
    logic [c_CNT_W-1:0]      w_cnt_inc;
    logic [c_IDX_W-1:0]      w_k;        // index of the byte arriving on mem_din
    logic [31:0]             w_ld_next;

    // An IO write with the UART buffer full is held off the bus; the byte
    // index freezes until the buffer drains.
    assign w_stall   = r_mem_wr && (r_mem_a[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign w_cnt_inc = r_cnt + 1'b1;
    // Byte k arrives two edges after its address was launched, i.e. when r_cnt == k+1
    assign w_k       = c_IDX_W'(r_cnt - 1'b1);

    always_comb begin
        w_ld_next                          = r_ld_buf;
        w_ld_next[{w_k[1:0], 3'b000} +: 8] = mem_din;
    end

    assign mem_a      = r_mem_a;
    assign mem_dout   = r_mem_dout;
    assign mem_wr     = r_mem_wr && rdy && !w_stall;
    assign if_done    = r_if_done;
    assign if_data    = r_if_data;
    assign lsb_done   = r_lsb_done;
    assign lsb_r_data = r_lsb_r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= MC_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_mem_wr     <= 1'b0;
            r_wdata      <= '0;
            r_ld_buf     <= '0;
            r_if_done    <= 1'b0;
            r_if_data    <= '0;
            r_lsb_done   <= 1'b0;
            r_lsb_r_data <= '0;
        end else if (rdy) begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            case (r_state)
                MC_IDLE: begin
                    r_cnt <= '0;
                    // A port whose done pulse is still high keeps its enable
                    // for this cycle; it must not be accepted a second time.
                    if (lsb_en && !r_lsb_done && lsb_wr) begin
                        r_state    <= MC_LW;
                        r_len      <= c_CNT_W'(lsb_len_bytes(lsb_len));
                        r_mem_a    <= lsb_addr;
                        r_mem_dout <= lsb_w_data[7:0];
                        r_wdata    <= lsb_w_data;
                        r_mem_wr   <= 1'b1;
                    end else if (lsb_en && !r_lsb_done && !rollback) begin
                        r_state  <= MC_LR;
                        r_len    <= c_CNT_W'(lsb_len_bytes(lsb_len));
                        r_mem_a  <= lsb_addr;
                        r_ld_buf <= '0;
                    end else if (if_en && !r_if_done) begin
                        r_state <= MC_IF;
                        r_len   <= c_LINE_N;
                        r_mem_a <= if_pc;
                    end
                end

                MC_IF, MC_LR: begin
                    if (r_state == MC_LR && rollback) begin
                        r_state <= MC_IDLE;
                        r_mem_a <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Launch the next address until all n have been issued
                        if (w_cnt_inc < r_len) begin
                            r_mem_a <= r_mem_a + 32'd1;
                        end else begin
                            r_mem_a <= '0;
                        end
                        if (r_cnt != '0) begin
                            if (r_state == MC_IF) begin
                                r_if_data[{w_k, 3'b000} +: 8] <= mem_din;
                            end else begin
                                r_ld_buf <= w_ld_next;
                            end
                        end
                        if (r_cnt == r_len) begin
                            r_state <= MC_IDLE;
                            if (r_state == MC_IF) begin
                                r_if_done <= 1'b1;
                            end else begin
                                r_lsb_done   <= 1'b1;
                                r_lsb_r_data <= w_ld_next;
                            end
                        end
                    end
                end

                MC_LW: begin
                    if (!w_stall) begin
                        if (w_cnt_inc == r_len) begin
                            r_state    <= MC_IDLE;
                            r_lsb_done <= 1'b1;
                            r_mem_wr   <= 1'b0;
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_mem_a    <= r_mem_a + 32'd1;
                            r_mem_dout <= r_wdata[15:8];
                            r_wdata    <= r_wdata >> 8;
                        end
                    end
                end

                default: begin
                    r_state  <= MC_IDLE;
                    r_mem_wr <= 1'b0;
                    r_mem_a  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte-wide
//               RAM model (unwritten locations read back addr[7:0]).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rdy = 1'b1;
    logic [7:0]   mem_din = 8'h00;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic         io_buffer_full = 1'b0;
    logic         if_en = 1'b0;
    logic [31:0]  if_pc = 32'h0;
    logic         if_done;
    logic [511:0] if_data;
    logic         lsb_en = 1'b0;
    logic         lsb_wr = 1'b0;
    logic [31:0]  lsb_addr = 32'h0;
    logic [1:0]   lsb_len = 2'b00;
    logic [31:0]  lsb_w_data = 32'h0;
    logic         lsb_done;
    logic [31:0]  lsb_r_data;
    logic         rollback = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_if  = 0;
    int n_lsb = 0;
    int nfull_wr = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] wa [$];
    logic [7:0]  wd [$];

    mem_ctrl #(.LINE_BYTES(64), .IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
        .rollback(rollback)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0];
    endfunction

    // RAM model: read data appears the cycle after its address
    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wa.push_back(mem_a);
            wd.push_back(mem_dout);
            if (io_buffer_full && mem_a[17:16] == 2'b11) nfull_wr++;
        end
    end

    always @(negedge clk) begin
        if (if_done === 1'b1) n_if++;
        if (lsb_done === 1'b1) n_lsb++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    // Wait (bounded) at negedges for a done pulse; reports the edge count it came on.
    task automatic wait_pulse(input bit want_if, input int limit, output int at_cyc, output bit seen);
        seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((want_if ? if_done : lsb_done) === 1'b1) begin
                seen = 1'b1;
                at_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got %h required 0", mem_a); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got %b required 0", mem_wr); end
        total++; if (if_done !== 1'b0 || lsb_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b%b required 00", if_done, lsb_done); end
        total++; if (if_data !== 512'h0 || lsb_r_data !== 32'h0 || mem_dout !== 8'h0) begin bad++; $display("FAIL reset_data got lsb_r_data=%h mem_dout=%h required 0", lsb_r_data, mem_dout); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_line_fill();
        int c, d, n0;
        bit ok;
        n0 = n_if;
        if_pc = 32'h1040; if_en = 1'b1; c = cyc;
        wait_pulse(1'b1, 200, d, ok);
        if_en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL line_timeout got no if_done required pulse"); end
        else begin
            total++; if (d - (c + 1) !== 65) begin bad++; $display("FAIL line_latency got %0d required 65", d - (c + 1)); end
            total++; if (if_data[31:0] !== 32'h43424140) begin bad++; $display("FAIL line_lo got %h required 43424140", if_data[31:0]); end
            total++; if (if_data[511:480] !== 32'h7F7E7D7C) begin bad++; $display("FAIL line_hi got %h required 7f7e7d7c", if_data[511:480]); end
        end
        repeat (5) @(negedge clk);
        total++; if (n_if - n0 !== 1) begin bad++; $display("FAIL line_pulses got %0d required 1", n_if - n0); end
    endtask

    task automatic test_loads();
        logic [31:0] t_addr [3] = '{32'h200, 32'h203, 32'h201};
        logic [1:0]  t_len  [3] = '{LSB_LEN_4, LSB_LEN_1, LSB_LEN_2};
        logic [31:0] t_exp  [3] = '{32'h44332211, 32'h00000044, 32'h00003322};
        int          t_lat  [3] = '{5, 2, 3};
        int c, d;
        bit ok;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = t_addr[i]; lsb_len = t_len[i]; c = cyc;
            wait_pulse(1'b0, 40, d, ok);
            lsb_en = 1'b0;
            total++;
            if (!ok) begin bad++; $display("FAIL load%0d_timeout got no lsb_done required pulse", i); end
            else begin
                total++; if (d - (c + 1) !== t_lat[i]) begin bad++; $display("FAIL load%0d_latency got %0d required %0d", i, d - (c + 1), t_lat[i]); end
                total++; if (lsb_r_data !== t_exp[i]) begin bad++; $display("FAIL load%0d_data got %h required %h", i, lsb_r_data, t_exp[i]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_priority();
        int c, d1, d2, n0i, n0l;
        bit ok;
        n0i = n_if; n0l = n_lsb;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h10; lsb_len = LSB_LEN_4;
        if_en = 1'b1; if_pc = 32'h2000; c = cyc;
        wait_pulse(1'b0, 40, d1, ok);
        lsb_en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL prio_lsb_timeout got no lsb_done required pulse"); end
        else begin
            total++; if (d1 - (c + 1) !== 5) begin bad++; $display("FAIL prio_lsb_latency got %0d required 5", d1 - (c + 1)); end
            total++; if (lsb_r_data !== 32'h13121110) begin bad++; $display("FAIL prio_lsb_data got %h required 13121110", lsb_r_data); end
        end
        wait_pulse(1'b1, 200, d2, ok);
        if_en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL prio_if_timeout got no if_done required pulse"); end
        else begin
            total++; if (d2 - d1 !== 66) begin bad++; $display("FAIL prio_if_latency got %0d required 66", d2 - d1); end
            total++; if (if_data[31:0] !== 32'h03020100) begin bad++; $display("FAIL prio_if_data got %h required 03020100", if_data[31:0]); end
        end
        repeat (5) @(negedge clk);
        total++; if (n_lsb - n0l !== 1 || n_if - n0i !== 1) begin bad++; $display("FAIL prio_pulses got lsb=%0d if=%0d required 1 1", n_lsb - n0l, n_if - n0i); end
    endtask

    task automatic test_io_store();
        logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int c, d;
        bit ok;
        wa.delete(); wd.delete(); nfull_wr = 0;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = LSB_LEN_4; lsb_w_data = 32'hDEADBEEF;
        c = cyc; ok = 1'b0; d = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (lsb_done === 1'b1) begin ok = 1'b1; d = cyc; end
            io_buffer_full = ((cyc - c) >= 2 && (cyc - c) <= 4);
        end
        io_buffer_full = 1'b0; lsb_en = 1'b0; lsb_wr = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL io_timeout got no lsb_done required pulse"); end
        else begin
            total++; if (d - (c + 1) !== 7) begin bad++; $display("FAIL io_latency got %0d required 7", d - (c + 1)); end
        end
        total++; if (wa.size() !== 4) begin bad++; $display("FAIL io_write_count got %0d required 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                total++;
                if (wa[i] !== 32'h30000 + i || wd[i] !== exp_b[i]) begin
                    bad++; $display("FAIL io_write%0d got %h:%h required %h:%h", i, wa[i], wd[i], 32'h30000 + i, exp_b[i]);
                end
            end
        end
        total++; if (nfull_wr !== 0) begin bad++; $display("FAIL io_write_while_full got %0d required 0", nfull_wr); end
        @(negedge clk);
    endtask

    task automatic test_rollback();
        int c, d, n0l;
        bit ok;
        n0l = n_lsb;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = LSB_LEN_4; c = cyc;
        @(negedge clk);
        @(negedge clk);
        rollback = 1'b1; if_en = 1'b1; if_pc = 32'h1000;
        @(negedge clk);
        rollback = 1'b0; lsb_en = 1'b0;
        total++; if (mem_a !== 32'h0 || lsb_done !== 1'b0) begin bad++; $display("FAIL rb_idle got mem_a=%h lsb_done=%b required 0 0", mem_a, lsb_done); end
        wait_pulse(1'b1, 200, d, ok);
        if_en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL rb_if_timeout got no if_done required pulse"); end
        else begin
            total++; if (d - c !== 69) begin bad++; $display("FAIL rb_if_latency got %0d required 69", d - c); end
            total++; if (if_data[31:0] !== 32'h03020100) begin bad++; $display("FAIL rb_if_data got %h required 03020100", if_data[31:0]); end
        end
        total++; if (lsb_r_data !== 32'h13121110 || n_lsb !== n0l) begin bad++; $display("FAIL rb_no_load got data=%h pulses=%0d required 13121110 0", lsb_r_data, n_lsb - n0l); end
        @(negedge clk);
    endtask

    task automatic test_rdy_freeze();
        logic [7:0] exp_b [4] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
        int c, d;
        bit ok;
        wa.delete(); wd.delete();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h400; lsb_len = LSB_LEN_4; lsb_w_data = 32'h0A0B0C0D;
        c = cyc; ok = 1'b0; d = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (lsb_done === 1'b1) begin ok = 1'b1; d = cyc; end
            rdy = !((cyc - c) >= 2 && (cyc - c) <= 3);
        end
        rdy = 1'b1; lsb_en = 1'b0; lsb_wr = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL rdy_timeout got no lsb_done required pulse"); end
        else begin
            total++; if (d - (c + 1) !== 6) begin bad++; $display("FAIL rdy_latency got %0d required 6", d - (c + 1)); end
        end
        total++; if (wa.size() !== 4) begin bad++; $display("FAIL rdy_write_count got %0d required 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                total++;
                if (wa[i] !== 32'h400 + i || wd[i] !== exp_b[i]) begin
                    bad++; $display("FAIL rdy_write%0d got %h:%h required %h:%h", i, wa[i], wd[i], 32'h400 + i, exp_b[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int c, d;
        bit ok;
        if_pc = 32'h1080; if_en = 1'b1; c = cyc;
        while (cyc - c < 32) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin bad++; $display("FAIL rst_mid_bus got a=%h wr=%b dout=%h required 0", mem_a, mem_wr, mem_dout); end
        total++; if (if_data !== 512'h0) begin bad++; $display("FAIL rst_mid_if_data got %h required 0", if_data[255:0]); end
        total++; if (if_done !== 1'b0 || lsb_done !== 1'b0 || lsb_r_data !== 32'h0) begin bad++; $display("FAIL rst_mid_lsb got done=%b%b r_data=%h required 0", if_done, lsb_done, lsb_r_data); end
        if_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if_en = 1'b1; c = cyc;
        wait_pulse(1'b1, 200, d, ok);
        if_en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL refill_timeout got no if_done required pulse"); end
        else begin
            total++; if (d - (c + 1) !== 65) begin bad++; $display("FAIL refill_latency got %0d required 65", d - (c + 1)); end
            total++; if (if_data[31:0] !== 32'h83828180) begin bad++; $display("FAIL refill_lo got %h required 83828180", if_data[31:0]); end
            total++; if (if_data[511:480] !== 32'hBFBEBDBC) begin bad++; $display("FAIL refill_hi got %h required bfbebdbc", if_data[511:480]); end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_line_fill();
        test_loads();
        test_priority();
        test_io_store();
        test_rollback();
        test_rdy_freeze();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the instruction line-fill interface, plus the load/store data port.
- Sits between the instruction-fetch unit, the load-store buffer, and the byte-wide unified RAM/IO bus.
- Serves 64-byte instruction line fills, and 1/2/4-byte loads and stores, one byte per cycle.
- Arbitrates between the two requesters: the LSB has priority.

Parameters:
LINE_BYTES, 64, bytes per instruction line; if_data width = 8*LINE_BYTES.
IO_ADDR_HI, 2'b11, value of addr[17:16] marking the IO region (0x30000 and above).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low, all state and outputs hold
mem_din  in  8  RAM read byte, valid in the cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full; stalls IO writes
if_en  in  1  line fill request; held high until if_done is seen
if_pc  in  32  line base address, 64-byte aligned
if_done  out  1  one-cycle pulse; if_data valid in the same cycle
if_data  out  512  line; byte k at bits [8k+7:8k] (little-endian)
lsb_en  in  1  LSB request; held until lsb_done
lsb_wr  in  1  1 = store, 0 = load
lsb_addr  in  32  byte address
lsb_len  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes
lsb_w_data  in  32  store data; byte k is written to addr+k
lsb_done  out  1  one-cycle completion pulse
lsb_r_data  out  32  load data, zero-extended; valid with lsb_done
rollback  in  1  misprediction flush; aborts an in-flight load

Behaviour:
- Reset (async, rst_n=0) sets every output to 0 and the state to IDLE; an in-flight transfer is discarded.
- States:
  - IDLE
  - IF_READ
  - LS_READ
  - LS_WRITE
- IDLE acceptance at edge E0, checked in this order:
  - lsb_en && lsb_wr → LS_WRITE.
  - else lsb_en && !rollback → LS_READ.
  - else if_en → IF_READ.
  - Acceptance latches the address, byte count n (64 for a line; 1/2/4 for LSB) and store data.
- Reads (IF_READ, LS_READ):
  - Addresses base+0..base+n-1 are driven in the cycles after E0..E(n-1), with mem_wr=0.
  - Byte k is sampled from mem_din at edge E(k+2).
  - The done pulse is registered at edge E(n+1): lines complete at E0+65, a word load at E0+5.
- Writes (LS_WRITE):
  - Byte k is driven with mem_wr=1 in the cycle after E(k).
  - lsb_done is registered at edge En.
- IO stall: if addr[17:16]==IO_ADDR_HI, mem_wr would be 1 and io_buffer_full=1, then force mem_wr=0, hold the byte index, and extend latency one cycle per stalled cycle.
- Done pulse and return to IDLE:
  - done is high for exactly one cycle; the FSM returns to IDLE on the same edge that raises done.
  - The requester drops its enable at the end of that cycle.
  - The FSM therefore must not re-accept during the done cycle. While done is high, IDLE ignores the enable of the port being completed.
- Rollback:
  - rollback=1 during LS_READ → IDLE next edge; no lsb_done, lsb_r_data unchanged.
  - LS_WRITE and IF_READ are unaffected by rollback, since stores are committed and the fetch unit keeps its request.
- rdy=0: freeze the FSM, counters and outputs, with mem_wr forced to 0; resume exactly where frozen.
- Idle outputs: mem_wr=0, mem_a=0.
- Width rules:
  - lsb_r_data bytes above n are 0; sign extension is the LSB's job.
  - Addresses use 32-bit wrap-around increment.

Decomposition:
- Shared constants header: state encodings (MC_IDLE, MC_IF, MC_LR, MC_LW), lsb_len encodings, IO_ADDR_HI.
- Single module; no sub-module warranted.
- Line assembly is a byte-indexed write into a 512-bit register.

Test Plan:
- Line fill: RAM[a]=a[7:0], if_en with if_pc=0x1040 → if_data[31:0]=0x43424140 and if_data[511:480]=0x7F7E7D7C; if_done high exactly once, 65 edges after acceptance.
- Load word: RAM[0x200..0x203]=11 22 33 44, lsb_len=10 → lsb_r_data=0x44332211 at E0+5. Load byte at 0x203 → 0x00000044 at E0+2.
- Simultaneous if_en and lsb_en load at 0x10 → LSB served first, fetch accepted in IDLE after lsb_done, then if_done 65 edges later; no duplicate done pulses.
- Store word 0xDEADBEEF to 0x30000 with io_buffer_full high for 3 cycles mid-transfer → 4 write cycles with bytes EF BE AD DE, lsb_done delayed by 3 cycles, no write while full.
- Rollback during a load's 2nd byte → FSM in IDLE next edge, no lsb_done; a pending if_en is then accepted normally.
- rst_n low at byte 30 of a line fill → all outputs 0 immediately. Re-issued if_en after release → full 65-edge fill with correct data.
